// File: rtl/serial_pkg.sv
// serial_pkg: definitions shared by the receive-side serial blocks.
//   rx_state_t     : receive FSM states
//   DATA_BITS_DEF  : default data bits per frame
//   OVERSAMPLE_DEF : default clocks per bit period
//   CNT_W          : width of the BitCounter Count bus
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    BREAK = 2'd3
  } rx_state_t;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 8;
  localparam int CNT_W          = 8;

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a single asynchronous bit.
//   clk   : sampling clock
//   reset : synchronous, active-high; both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronized output, two clocks behind d
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_rx_ctrl.sv
// serial_rx_ctrl: receive control FSM for the serial link.
// Oversamples SerIn (start bit, DATA_BITS data bits LSB first, one stop bit),
// assembles the word and drives the BitCounter strobes. The data phase ends
// when the counter's Count reaches DATA_BITS; that sample is the stop bit.
//   clk          : clock, rising edge
//   reset        : synchronous, active-high
//   SerIn        : asynchronous serial line, idle high
//   Count        : BitCounter count (two edges behind the strobes)
//   ClearCounter : one-cycle pulse at a confirmed start bit
//   IncCounter   : one-cycle pulse per captured data bit
//   Data         : last good word, held until the next good frame
//   DataValid    : one-cycle pulse when Data updates
//   FrameError   : one-cycle pulse when the stop bit is sampled low
//   Busy         : high whenever the FSM is not in IDLE
module serial_rx_ctrl
  import serial_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 SerIn,
  input  logic [CNT_W-1:0]     Count,
  output logic                 ClearCounter,
  output logic                 IncCounter,
  output logic [DATA_BITS-1:0] Data,
  output logic                 DataValid,
  output logic                 FrameError,
  output logic                 Busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]    T_HALF = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0]    T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] N_BITS = CNT_W'(DATA_BITS);

  logic                 rx;
  rx_state_t            state;
  logic [TW-1:0]        timer;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shift_nxt;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (SerIn),
    .q     (rx)
  );

  // LSB-first line: each new bit enters at the MSB and moves down, so after
  // DATA_BITS shifts the first bit received sits in bit 0.
  if (DATA_BITS > 1) begin : g_shift
    assign shift_nxt = {rx, shreg[DATA_BITS-1:1]};
  end else begin : g_shift1
    assign shift_nxt = rx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      shreg        <= '0;
      Data         <= '0;
      ClearCounter <= 1'b0;
      IncCounter   <= 1'b0;
      DataValid    <= 1'b0;
      FrameError   <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      ClearCounter <= 1'b0;
      IncCounter   <= 1'b0;
      DataValid    <= 1'b0;
      FrameError   <= 1'b0;
      timer        <= timer + 1'b1;

      case (state)
        IDLE: begin
          timer <= '0;
          if (!rx) begin
            state <= START;
            Busy  <= 1'b1;
          end
        end

        // Re-check the line half a bit in to reject short glitches.
        START: begin
          if (timer == T_HALF) begin
            timer <= '0;
            if (!rx) begin
              state        <= DATA;
              ClearCounter <= 1'b1;
            end else begin
              state <= IDLE;
              Busy  <= 1'b0;
            end
          end
        end

        // Sampling at mid bit; the counter decides data vs stop. Count has
        // settled well before the next mid-bit sample since OVERSAMPLE >= 4.
        // Returning to IDLE at mid stop bit leaves half a bit of margin to
        // catch a back-to-back start edge.
        DATA: begin
          if (timer == T_FULL) begin
            timer <= '0;
            if (Count < N_BITS) begin
              shreg      <= shift_nxt;
              IncCounter <= 1'b1;
            end else if (Count == N_BITS && rx) begin
              Data      <= shreg;
              DataValid <= 1'b1;
              state     <= IDLE;
              Busy      <= 1'b0;
            end else begin
              // Low stop bit, or an out-of-range count treated the same way.
              FrameError <= 1'b1;
              state      <= BREAK;
            end
          end
        end

        // Wait out a held-low line before looking for a new start bit.
        BREAK: begin
          timer <= '0;
          if (rx) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// tb_serial_rx_ctrl: directed + randomized bench for serial_rx_ctrl.
// Two DUTs (defaults, and DATA_BITS=5/OVERSAMPLE=4), each with a BitCounter
// model. A frame-level model predicts, from the cycle the start bit is driven,
// the cycle of every strobe and result pulse; a negedge monitor records what
// the DUT actually produced and the two event lists are compared.
module tb_serial_rx_ctrl;
  import serial_pkg::*;

  localparam int EV_CLR = 1, EV_INC = 2, EV_DV = 3, EV_FE = 4;

  typedef struct {
    int kind;
    int cyc;
    int data;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- DUT A: defaults ----------------
  logic             SerIn_a;
  logic [CNT_W-1:0] Count_a, cnt_int_a;
  logic             clr_a, inc_a, dv_a, fe_a, busy_a;
  logic [7:0]       Data_a;

  serial_rx_ctrl u_dut_a (
    .clk          (clk),
    .reset        (reset),
    .SerIn        (SerIn_a),
    .Count        (Count_a),
    .ClearCounter (clr_a),
    .IncCounter   (inc_a),
    .Data         (Data_a),
    .DataValid    (dv_a),
    .FrameError   (fe_a),
    .Busy         (busy_a)
  );

  // ---------------- DUT B: 5 bits, 4x oversample ----------------
  logic             SerIn_b;
  logic [CNT_W-1:0] Count_b, cnt_int_b;
  logic             clr_b, inc_b, dv_b, fe_b, busy_b;
  logic [4:0]       Data_b;

  serial_rx_ctrl #(.DATA_BITS(5), .OVERSAMPLE(4)) u_dut_b (
    .clk          (clk),
    .reset        (reset),
    .SerIn        (SerIn_b),
    .Count        (Count_b),
    .ClearCounter (clr_b),
    .IncCounter   (inc_b),
    .Data         (Data_b),
    .DataValid    (dv_b),
    .FrameError   (fe_b),
    .Busy         (busy_b)
  );

  // BitCounter models: strobe seen on one edge, Count visible after the next.
  always @(posedge clk) begin
    if (reset) begin
      cnt_int_a <= '0; Count_a <= '0;
      cnt_int_b <= '0; Count_b <= '0;
    end else begin
      if (clr_a) cnt_int_a <= '0; else if (inc_a) cnt_int_a <= cnt_int_a + 1'b1;
      if (clr_b) cnt_int_b <= '0; else if (inc_b) cnt_int_b <= cnt_int_b + 1'b1;
      Count_a <= cnt_int_a;
      Count_b <= cnt_int_b;
    end
  end

  ev_t obs_a[$], exp_a[$], obs_b[$], exp_b[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Monitor: record pulses with the index of the edge that raised them.
  logic busy_prev_a = 1'b0, busy_prev_b = 1'b0;
  always @(negedge clk) begin
    if (clr_a) obs_a.push_back('{EV_CLR, cyc, 0});
    if (inc_a) obs_a.push_back('{EV_INC, cyc, 0});
    if (dv_a)  obs_a.push_back('{EV_DV,  cyc, int'(Data_a)});
    if (fe_a)  obs_a.push_back('{EV_FE,  cyc, 0});
    if (clr_b) obs_b.push_back('{EV_CLR, cyc, 0});
    if (inc_b) obs_b.push_back('{EV_INC, cyc, 0});
    if (dv_b)  obs_b.push_back('{EV_DV,  cyc, int'(Data_b)});
    if (fe_b)  obs_b.push_back('{EV_FE,  cyc, 0});
    if (clr_a || inc_a) chk("strobe_excl_a", {31'd0, clr_a & inc_a}, 32'd0);
    if (clr_b || inc_b) chk("strobe_excl_b", {31'd0, clr_b & inc_b}, 32'd0);
    if (dv_a) begin
      chk("busy_falls_with_dv_a", {31'd0, busy_a}, 32'd0);
      chk("busy_before_dv_a", {31'd0, busy_prev_a}, 32'd1);
    end
    busy_prev_a = busy_a;
    busy_prev_b = busy_b;
  end

  // Frame-level reference: start bit driven on cycle c is seen by the FSM
  // 3 edges later (E); the start is confirmed half a bit after E, and every
  // later sample is one full bit apart. The sample after the last data bit
  // is the stop bit.
  task automatic expect_frame(input int which, input int c, input logic [7:0] d,
                              input logic stop);
    int os, nb, t;
    ev_t e[$];
    os = (which == 0) ? 8 : 4;
    nb = (which == 0) ? 8 : 5;
    t  = c + 3 + os/2;
    e.push_back('{EV_CLR, t, 0});
    for (int k = 1; k <= nb; k++) e.push_back('{EV_INC, t + k*os, 0});
    if (stop) e.push_back('{EV_DV, t + (nb+1)*os, int'(d) & ((1 << nb) - 1)});
    else      e.push_back('{EV_FE, t + (nb+1)*os, 0});
    foreach (e[i]) begin
      if (which == 0) exp_a.push_back(e[i]); else exp_b.push_back(e[i]);
    end
  endtask

  task automatic cmp_events(input string tag, input int which);
    ev_t o[$], e[$];
    if (which == 0) begin
      o = obs_a; e = exp_a; obs_a.delete(); exp_a.delete();
    end else begin
      o = obs_b; e = exp_b; obs_b.delete(); exp_b.delete();
    end
    chk({tag, "_nevents"}, o.size(), e.size());
    for (int i = 0; i < o.size() && i < e.size(); i++) begin
      chk($sformatf("%s_ev%0d_kind", tag, i), o[i].kind, e[i].kind);
      chk($sformatf("%s_ev%0d_cyc",  tag, i), o[i].cyc,  e[i].cyc);
      chk($sformatf("%s_ev%0d_data", tag, i), o[i].data, e[i].data);
    end
  endtask

  // Hold a line level for n clocks; called right after a negedge.
  task automatic drive(input int which, input logic v, input int n);
    if (which == 0) SerIn_a = v; else SerIn_b = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input logic stop);
    int os, nb;
    os = (which == 0) ? 8 : 4;
    nb = (which == 0) ? 8 : 5;
    expect_frame(which, cyc, d, stop);
    drive(which, 1'b0, os);
    for (int i = 0; i < nb; i++) drive(which, d[i], os);
    drive(which, stop, os);
  endtask

  logic [7:0] last_good;
  logic [7:0] rnd;
  int         c0;

  initial begin
    reset = 1'b1; SerIn_a = 1'b1; SerIn_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy_a",  {31'd0, busy_a}, 32'd0);
    chk("rst_data_a",  {24'd0, Data_a}, 32'd0);
    chk("rst_strb_a",  {28'd0, clr_a, inc_a, dv_a, fe_a}, 32'd0);
    chk("rst_busy_b",  {31'd0, busy_b}, 32'd0);
    chk("rst_data_b",  {27'd0, Data_b}, 32'd0);
    reset = 1'b0;
    drive(0, 1'b1, 4);
    cmp_events("reset_idle", 0);

    // Single good frame.
    send_frame(0, 8'hA5, 1'b1);
    drive(0, 1'b1, 5);
    cmp_events("a5", 0);
    chk("a5_data_held", {24'd0, Data_a}, 32'hA5);
    last_good = 8'hA5;

    // Two-clock glitch: rejected at the mid-start check.
    drive(0, 1'b0, 2);
    drive(0, 1'b1, 3);
    chk("glitch_busy_mid", {31'd0, busy_a}, 32'd1);
    drive(0, 1'b1, 5);
    chk("glitch_busy_low", {31'd0, busy_a}, 32'd0);
    cmp_events("glitch", 0);
    chk("glitch_data", {24'd0, Data_a}, {24'd0, last_good});

    // Bad stop bit, line held low, then recovery.
    send_frame(0, 8'h3C, 1'b0);
    drive(0, 1'b0, 10);
    chk("break_busy_mid", {31'd0, busy_a}, 32'd1);
    drive(0, 1'b0, 10);
    chk("break_busy_end", {31'd0, busy_a}, 32'd1);
    chk("break_data_kept", {24'd0, Data_a}, {24'd0, last_good});
    drive(0, 1'b1, 4);
    chk("break_busy_release", {31'd0, busy_a}, 32'd0);
    send_frame(0, 8'h81, 1'b1);
    drive(0, 1'b1, 5);
    cmp_events("break_3c_then_81", 0);
    last_good = 8'h81;

    // Back-to-back: DataValid pulses land exactly one frame (80 clocks) apart.
    send_frame(0, 8'h00, 1'b1);
    send_frame(0, 8'hFF, 1'b1);
    send_frame(0, 8'h5A, 1'b1);
    drive(0, 1'b1, 5);
    cmp_events("b2b", 0);
    chk("b2b_data", {24'd0, Data_a}, 32'h5A);

    // Reset during the 4th data bit of 0x77: three bits captured, no result.
    c0 = cyc;
    exp_a.push_back('{EV_CLR, c0 + 7,  0});
    exp_a.push_back('{EV_INC, c0 + 15, 0});
    exp_a.push_back('{EV_INC, c0 + 23, 0});
    exp_a.push_back('{EV_INC, c0 + 31, 0});
    drive(0, 1'b0, 8);
    drive(0, 1'b1, 8);
    drive(0, 1'b1, 8);
    drive(0, 1'b1, 8);
    drive(0, 1'b0, 4);
    SerIn_a = 1'b1;
    reset   = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    chk("midrst_busy", {31'd0, busy_a}, 32'd0);
    chk("midrst_data", {24'd0, Data_a}, 32'd0);
    drive(0, 1'b1, 90);
    cmp_events("midrst", 0);
    send_frame(0, 8'h12, 1'b1);
    drive(0, 1'b1, 3);
    cmp_events("after_rst_12", 0);

    // Randomized good frames with random idle gaps.
    for (int i = 0; i < 6; i++) begin
      rnd = 8'($urandom);
      send_frame(0, rnd, 1'b1);
      drive(0, 1'b1, $urandom_range(0, 15));
      last_good = rnd;
    end
    drive(0, 1'b1, 3);
    cmp_events("random", 0);
    chk("random_data_held", {24'd0, Data_a}, {24'd0, last_good});

    // Narrow instance: 5 bits at 4x; result 26 clocks after START entry.
    cmp_events("b_quiet", 1);
    send_frame(1, 8'h15, 1'b1);
    drive(1, 1'b1, 4);
    cmp_events("b_15", 1);
    chk("b_15_data", {27'd0, Data_b}, 32'h15);
    rnd = 8'($urandom_range(0, 31));
    send_frame(1, rnd, 1'b1);
    send_frame(1, 8'h0A, 1'b0);
    drive(1, 1'b1, 6);
    cmp_events("b_rand_fe", 1);
    chk("b_data_kept", {27'd0, Data_b}, {27'd0, rnd[4:0]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
